// File: rtl/sample_stream_pkg.sv
// Shared types and default constants for the sample streamer and the
// minmax_filter benches that reuse its timing.
package sample_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2,
    ST_GAP   = 2'd3
  } stream_state_t;

  localparam int unsigned DEFAULT_SAMPLE_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_SAMPLE_PERIOD     = 800;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running modulo-PERIOD counter with a one-cycle tick on its last
// count and a synchronous clear back to zero.
module sample_tick_gen
  import sample_stream_pkg::*;
#(
  parameter int unsigned PERIOD = DEFAULT_SAMPLE_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = (r_count == LAST);

endmodule

// File: rtl/sample_streamer.sv
// Streams SAMPLE_COUNT words from a fixed-latency sample memory as axiov
// strobes spaced SAMPLE_PERIOD cycles apart. Define SAMPLE_STREAMER_LOOP_EN
// to wrap the address and stream continuously instead of a single pass.
module sample_streamer
  import sample_stream_pkg::*;
#(
  parameter int unsigned SAMPLE_DATA_WIDTH = DEFAULT_SAMPLE_DATA_WIDTH,
  parameter int unsigned SAMPLE_COUNT      = 7000,
  parameter int unsigned SAMPLE_PERIOD     = DEFAULT_SAMPLE_PERIOD,
  parameter int unsigned READ_LATENCY      = 2,
  parameter int unsigned ADDR_WIDTH        = $clog2(SAMPLE_COUNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [SAMPLE_DATA_WIDTH-1:0] mem_data,
  output logic                         axiov,
  output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
  output logic                         busy,
  output logic                         done
);

`ifdef SAMPLE_STREAMER_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  localparam int unsigned         LAT_W     = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0]    LAT_LAST  = LAT_W'(READ_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(SAMPLE_COUNT - 1);

  stream_state_t                r_state;
  logic [ADDR_WIDTH-1:0]        r_addr;
  logic [LAT_W-1:0]             r_lat;
  logic                         r_last;
  logic                         r_axiov;
  logic [SAMPLE_DATA_WIDTH-1:0] r_axiod;
  logic                         r_busy;
  logic                         r_done;

  logic                  w_tick;
  logic                  w_tick_clear;
  logic                  w_is_last;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  // Holding the period counter clear until the first strobe lines every
  // later tick up with the cycle before each EMIT.
  assign w_tick_clear = (r_state == ST_IDLE) || (r_state == ST_FETCH);

  sample_tick_gen #(
    .PERIOD(SAMPLE_PERIOD)
  ) u_tick_gen (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clear(w_tick_clear),
    .o_tick (w_tick)
  );

  assign w_is_last   = (r_addr == ADDR_LAST);
  assign w_next_addr = w_is_last ? '0 : r_addr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_lat   <= '0;
      r_last  <= 1'b0;
      r_axiov <= 1'b0;
      r_axiod <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (stop && (r_state != ST_IDLE)) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_lat   <= '0;
      r_last  <= 1'b0;
      r_axiov <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_axiov <= 1'b0;
          r_done  <= 1'b0;
          if (start && !stop) begin
            r_state <= ST_FETCH;
            r_busy  <= 1'b1;
            r_addr  <= '0;
            r_lat   <= '0;
            r_last  <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (r_lat == LAT_LAST) begin
            r_state <= ST_EMIT;
            r_axiov <= 1'b1;
            r_axiod <= mem_data;
            r_last  <= w_is_last;
            r_addr  <= w_next_addr;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        ST_EMIT: begin
          r_state <= ST_GAP;
          r_axiov <= 1'b0;
          r_done  <= r_last;
        end
        ST_GAP: begin
          r_done <= 1'b0;
          // The first GAP cycle after the final sample carries the done pulse.
          if (r_last && !LOOP_EN) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
          end else if (w_tick) begin
            r_state <= ST_EMIT;
            r_axiov <= 1'b1;
            r_axiod <= mem_data;
            r_last  <= w_is_last;
            r_addr  <= w_next_addr;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr = r_addr;
  assign axiov    = r_axiov;
  assign axiod    = r_axiod;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_sample_streamer.sv
// Directed bench for sample_streamer: 4 samples, period 5, read latency 2.
// Expectations follow SAMPLE_STREAMER_LOOP_EN when it is defined.
module tb_sample_streamer;

  localparam int unsigned DW   = 8;
  localparam int unsigned CNT  = 4;
  localparam int unsigned PER  = 5;
  localparam int unsigned RL   = 2;
  localparam int unsigned AW   = 2;
  localparam int          NCYC = 50;

`ifdef SAMPLE_STREAMER_LOOP_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          axiov;
  logic [DW-1:0] axiod;
  logic          busy;
  logic          done;

  logic [DW-1:0] w_word;
  logic [DW-1:0] r_pipe;
  logic [DW-1:0] c_words [CNT];

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0]   obs_v;
  logic [63:0]   obs_done;
  logic [63:0]   obs_busy;
  logic [DW-1:0] obs_d    [NCYC];
  logic [AW-1:0] obs_addr [NCYC];

  always #5 clk = ~clk;

  sample_streamer #(
    .SAMPLE_DATA_WIDTH(DW),
    .SAMPLE_COUNT     (CNT),
    .SAMPLE_PERIOD    (PER),
    .READ_LATENCY     (RL),
    .ADDR_WIDTH       (AW)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .axiov   (axiov),
    .axiod   (axiod),
    .busy    (busy),
    .done    (done)
  );

  // Two-stage read pipeline: data appears two cycles after the address.
  always_comb begin
    w_word = 8'h00;
    case (mem_addr)
      2'd0: w_word = 8'h11;
      2'd1: w_word = 8'h22;
      2'd2: w_word = 8'h33;
      2'd3: w_word = 8'h44;
      default: w_word = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    r_pipe   <= w_word;
    mem_data <= r_pipe;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] pulses(input int first, input int step, input int last);
    logic [63:0] m;
    m = '0;
    for (int i = first; i <= last; i += step) m[i] = 1'b1;
    return m;
  endfunction

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Cycle 0 is the cycle in which start is first driven; each observation
  // holds the outputs visible during that cycle.
  task automatic run(input int start_last, input int stop_cyc, input logic stop_hold,
                     input int rst_cyc, input int restart_cyc);
    obs_v    = '0;
    obs_done = '0;
    obs_busy = '0;
    for (int c = 0; c < NCYC; c++) begin
      obs_v[c]    = axiov;
      obs_done[c] = done;
      obs_busy[c] = busy;
      obs_d[c]    = axiod;
      obs_addr[c] = mem_addr;
      start = (c <= start_last) || (c == restart_cyc);
      stop  = stop_hold || (c == stop_cyc);
      rst   = (c == rst_cyc);
      @(posedge clk); #1;
    end
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    c_words[0] = 8'h11;
    c_words[1] = 8'h22;
    c_words[2] = 8'h33;
    c_words[3] = 8'h44;

    do_reset();
    check_val("reset axiov",    64'(axiov),    64'h0);
    check_val("reset axiod",    64'(axiod),    64'h0);
    check_val("reset busy",     64'(busy),     64'h0);
    check_val("reset done",     64'(done),     64'h0);
    check_val("reset mem_addr", 64'(mem_addr), 64'h0);

    // Single start pulse: full pass.
    run(0, -1, 1'b0, -1, -1);
    check_val("pass axiov pattern", obs_v, LOOP ? pulses(4, 5, 49) : pulses(4, 5, 19));
    for (int k = 0; k < 4; k++)
      check_val($sformatf("pass axiod sample %0d", k), 64'(obs_d[4 + 5 * k]), 64'(c_words[k]));
    check_val("pass axiod before first", 64'(obs_d[3]), 64'h0);
    check_val("pass axiod hold in gap",  64'(obs_d[8]), 64'h11);
    check_val("pass mem_addr cycle 1",   64'(obs_addr[1]), 64'h0);
    check_val("pass mem_addr cycle 5",   64'(obs_addr[5]), 64'h1);
    check_val("pass done pattern", obs_done, LOOP ? pulses(20, 20, 40) : pulses(20, 20, 20));
    check_val("pass busy pattern", obs_busy, LOOP ? span(1, 49) : span(1, 20));
    check_val("pass axiod cycle 24", 64'(obs_d[24]), LOOP ? 64'h11 : 64'h44);

    // Stop during the second gap.
    do_reset();
    run(0, 10, 1'b0, -1, -1);
    check_val("stop axiov pattern", obs_v, pulses(4, 5, 9));
    check_val("stop done pattern",  obs_done, 64'h0);
    check_val("stop busy pattern",  obs_busy, span(1, 10));
    check_val("stop axiod sample 1", 64'(obs_d[9]), 64'h22);

    // Start held high while busy must not restart the pass.
    do_reset();
    run(12, -1, 1'b0, -1, -1);
    check_val("held start axiov pattern", obs_v, LOOP ? pulses(4, 5, 49) : pulses(4, 5, 19));
    check_val("held start done pattern", obs_done, LOOP ? pulses(20, 20, 40) : pulses(20, 20, 20));
    check_val("held start axiod sample 3", 64'(obs_d[19]), 64'h44);

    // Reset mid-pass, then a fresh start.
    do_reset();
    run(0, -1, 1'b0, 7, 30);
    check_val("rst cycle 8 axiov",    64'(obs_v[8]),    64'h0);
    check_val("rst cycle 8 axiod",    64'(obs_d[8]),    64'h0);
    check_val("rst cycle 8 busy",     64'(obs_busy[8]), 64'h0);
    check_val("rst cycle 8 done",     64'(obs_done[8]), 64'h0);
    check_val("rst cycle 8 mem_addr", 64'(obs_addr[8]), 64'h0);
    check_val("rst axiov pattern", obs_v, pulses(4, 5, 4) | pulses(34, 5, 49));
    check_val("rst restart axiod", 64'(obs_d[34]), 64'h11);
    check_val("rst done pattern",  obs_done, 64'h0);
    check_val("rst busy pattern",  obs_busy, span(1, 7) | span(31, 49));

    // start and stop together in IDLE.
    do_reset();
    run(NCYC, -1, 1'b1, -1, -1);
    check_val("start+stop busy",  obs_busy, 64'h0);
    check_val("start+stop axiov", obs_v,    64'h0);
    check_val("start+stop done",  obs_done, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_streamer.md
SAMPLE_STREAMER -- requirements
Module: sample_streamer

Interface
REQ-001 SHALL have parameter SAMPLE_DATA_WIDTH, default 8, width of each sample word.
REQ-002 SHALL have parameter SAMPLE_COUNT, default 7000, number of samples per pass (addresses 0..SAMPLE_COUNT-1).
REQ-003 SHALL have parameter SAMPLE_PERIOD, default 800, clk cycles between consecutive axiov pulses; legal range >= READ_LATENCY+2.
REQ-004 SHALL have parameter READ_LATENCY, default 2, cycles from mem_addr change to matching mem_data.
REQ-005 SHALL have parameter ADDR_WIDTH, default $clog2(SAMPLE_COUNT), sample memory address width.
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  begin a pass; sampled only in IDLE.
REQ-009 stop  input  1  abort streaming; sampled in every state.
REQ-010 mem_addr  output  ADDR_WIDTH  registered read address to sample memory.
REQ-011 mem_data  input  SAMPLE_DATA_WIDTH  read data, valid READ_LATENCY cycles after mem_addr.
REQ-012 axiov  output  1  one-cycle sample-valid strobe.
REQ-013 axiod  output  SAMPLE_DATA_WIDTH  sample word, registered, qualified by axiov.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 done  output  1  one-cycle pulse at end of each pass.

Function
REQ-016 States SHALL be IDLE, FETCH, EMIT, GAP.
REQ-017 IDLE + start=1 + stop=0 at edge t0: SHALL go FETCH, mem_addr=0 from t0+1; start=1 with stop=1 SHALL stay IDLE.
REQ-018 FETCH SHALL wait READ_LATENCY cycles, then latch mem_data into axiod and go EMIT; first axiov SHALL be high in cycle t0+2+READ_LATENCY.
REQ-019 EMIT SHALL last exactly one cycle with axiov=1; mem_addr SHALL increment in the same cycle.
REQ-020 GAP SHALL hold axiov=0 and latch mem_data READ_LATENCY cycles after the address change; axiod SHALL change only on the cycle axiov rises.
REQ-021 Consecutive axiov rising edges SHALL be exactly SAMPLE_PERIOD cycles apart; no jitter.
REQ-022 axiod during EMIT SHALL equal the memory word at the address issued for that sample; samples emitted in ascending address order.
REQ-023 After EMIT of address SAMPLE_COUNT-1: done=1 for one cycle the next cycle, then IDLE (LOOP_EN undefined).
REQ-024 stop=1 in any non-IDLE state SHALL force IDLE next cycle, axiov=0 that cycle, no done pulse; stop and EMIT in the same cycle: the EMIT strobe still occurs, then IDLE.
REQ-025 start while busy SHALL be ignored.
REQ-026 Period counter SHALL use $clog2(SAMPLE_PERIOD) bits, wrapping at SAMPLE_PERIOD-1, no overflow.

Reset
REQ-027 rst SHALL override all inputs, including start and stop.
REQ-028 On rst: state IDLE, mem_addr=0, axiov=0, axiod=0, busy=0, done=0, period counter 0; rst mid-pass SHALL discard the pass with no done.

Configuration
REQ-029 Macro SAMPLE_STREAMER_LOOP_EN defined: after address SAMPLE_COUNT-1, mem_addr SHALL wrap to 0 and streaming continues with period unchanged, done pulses each wrap, busy stays 1 until stop or rst.
REQ-030 Macro undefined: single pass per start per REQ-023.

Structure
REQ-031 Package sample_stream_pkg SHALL hold the state enum and default SAMPLE_DATA_WIDTH/SAMPLE_PERIOD constants shared with minmax_filter benches.
REQ-032 Sub-module sample_tick_gen SHALL implement the SAMPLE_PERIOD counter with a one-cycle tick output and a synchronous clear.

Verification (SAMPLE_COUNT=4, SAMPLE_PERIOD=5, READ_LATENCY=2, memory {0x11,0x22,0x33,0x44})
REQ-033 start at cycle 0 -> axiov at cycles 4,9,14,19 with axiod 0x11,0x22,0x33,0x44; done at cycle 20; busy 0 from cycle 21.
REQ-034 stop at cycle 10 -> axiov only at 4,9; IDLE at 11; no done.
REQ-035 start held high through cycle 12 -> no restart; pulse sequence identical to REQ-033.
REQ-036 rst at cycle 7 -> all outputs 0 at cycle 8; later start at 30 -> first axiov at 34 with 0x11.
REQ-037 LOOP_EN defined, start at 0 -> axiov at 24 with 0x11, done at 20 and 40, busy held high.
REQ-038 start=1 and stop=1 together in IDLE -> busy stays 0, no axiov for 50 cycles.
